// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8-bit UART transmit engine (8N1, or 8E1 when built with
// UART_TX_PARITY_EN defined). A byte is accepted on a valid/ready handshake,
// then sent LSB-first at a runtime baud divisor of N = max(baud_div, 1) clocks
// per bit. busy/done let the register block derive its status from the line.
module uart_tx_serializer #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Control state (reset)
  state_t            state_q, state_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;

  // Datapath state (not reset; always reloaded on handshake)
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  div_q, div_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic [DIV_W-1:0]  load_div;

  // Next-state logic: the baud counter holds N-1 on entry to every bit and
  // the bit ends on the cycle it reads zero, so N=1 gives one clock per bit.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    div_d     = div_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    load_div  = (baud_div == '0) ? '0 : baud_div - 1'b1;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (s_valid && ready_q) begin
          state_d   = START;
          tx_d      = 1'b0;
          cnt_d     = load_div;
          div_d     = load_div;
          shift_d   = s_data;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^s_data;
`endif
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          cnt_d     = div_q;
          bit_cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_q;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    done_d  = (state_d == STOP) && (cnt_d == '0);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // Control registers with synchronous active-low reset; a mid-frame reset
  // drops the line high on the same edge and suppresses done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Datapath registers: payload shifter and latched divisor.
  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
    div_q    <= div_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign s_ready = ready_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for uart_tx_serializer. Expected line
// samples are queued at each accepted byte and compared one per clock.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] baud_div = 16'd1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, tx, busy, done;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit mon_en = 1'b0;
  logic sb[$];
  logic mon_exp, mon_done;

  uart_tx_serializer #(.DIV_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .baud_div(baud_div), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Expected tx samples for one frame of N clocks per bit.
  task automatic push_frame(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) sb.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < n; i++) sb.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < n; i++) sb.push_back(^d);
`endif
    for (int i = 0; i < n; i++) sb.push_back(1'b1);
  endtask

  // Line monitor: one expected sample per clock while a frame is queued;
  // outside frames done must stay low and an idle engine must hold tx high.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0) begin
        mon_exp  = sb.pop_front();
        mon_done = (sb.size() == 0);
        total_cnt++;
        if (tx !== mon_exp || done !== mon_done || busy !== 1'b1)
          $display("FAIL line_sample: got tx=%b done=%b busy=%b required tx=%b done=%b busy=1 (t=%0t)",
                   tx, done, busy, mon_exp, mon_done, $time);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (done !== 1'b0 || (busy === 1'b0 && tx !== 1'b1))
          $display("FAIL line_idle: got tx=%b done=%b busy=%b required done=0 and tx=1 when idle (t=%0t)",
                   tx, done, busy, $time);
        else pass_cnt++;
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (tx !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_state: got tx=%b s_ready=%b busy=%b done=%b required 1 1 0 0",
               tx, s_ready, busy, done);
    else pass_cnt++;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk); #1;
  endtask

  // One frame: latency, frame length, busy length and post-frame idle state.
  task automatic test_frame(input logic [7:0] d, input logic [15:0] div);
    int n, len, w, busy_cyc, done_at;
    n   = (div == 16'd0) ? 1 : int'(div);
    len = n * FRAME_BITS;
    s_data = d; baud_div = div; s_valid = 1'b1;
    w = 0;
    while (s_ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
    total_cnt++;
    if (s_ready !== 1'b1) $display("FAIL frame_ready: got s_ready=%b required 1", s_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    push_frame(d, n);
    s_valid = 1'b0;
    baud_div = ~div;
    s_data = ~d;
    total_cnt++;
    if (tx !== 1'b0 || busy !== 1'b1)
      $display("FAIL frame_start_latency: got tx=%b busy=%b required tx=0 busy=1", tx, busy);
    else pass_cnt++;
    busy_cyc = 0; done_at = 0;
    for (int c = 1; c <= len + 5; c++) begin
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1 && done_at == 0) done_at = c;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (done_at != len) $display("FAIL frame_done_cycle: got %0d required %0d", done_at, len);
    else pass_cnt++;
    total_cnt++;
    if (busy_cyc != len) $display("FAIL frame_busy_cycles: got %0d required %0d", busy_cyc, len);
    else pass_cnt++;
    total_cnt++;
    if (sb.size() != 0 || tx !== 1'b1 || s_ready !== 1'b1)
      $display("FAIL frame_end_idle: got left=%0d tx=%b s_ready=%b required 0 1 1", sb.size(), tx, s_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int w;
    s_data = 8'h55; baud_div = 16'd3; s_valid = 1'b1;
    w = 0;
    while (s_ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    push_frame(8'h55, 3);
    s_data = 8'hAA; baud_div = 16'd2;
    total_cnt++;
    if (s_ready !== 1'b0) $display("FAIL b2b_ready_low: got s_ready=%b required 0", s_ready);
    else pass_cnt++;
    w = 0;
    while (done !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
    total_cnt++;
    if (w != 29) $display("FAIL b2b_first_done: got %0d cycles required 29", w);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (s_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL b2b_gap: got s_ready=%b tx=%b busy=%b required 1 1 0", s_ready, tx, busy);
    else pass_cnt++;
    @(posedge clk); #1;
    push_frame(8'hAA, 2);
    s_valid = 1'b0;
    total_cnt++;
    if (tx !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_second_start: got tx=%b busy=%b required 0 1", tx, busy);
    else pass_cnt++;
    w = 0;
    while (sb.size() != 0 && w < 200) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    total_cnt++;
    if (sb.size() != 0 || busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL b2b_end: got left=%0d busy=%b tx=%b required 0 0 1", sb.size(), busy, tx);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    int w;
    d = 8'hB6;
    s_data = d; baud_div = 16'd8; s_valid = 1'b1;
    w = 0;
    while (s_ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    push_frame(d, 8);
    s_valid = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    total_cnt++;
    if (tx !== d[3]) $display("FAIL abort_bit3: got tx=%b required %b", tx, d[3]);
    else pass_cnt++;
    reset_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    total_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL abort_reset: got tx=%b busy=%b s_ready=%b done=%b required 1 0 1 0",
               tx, busy, s_ready, done);
    else pass_cnt++;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL abort_quiet: got tx=%b busy=%b required 1 0", tx, busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, 16'd4);
    test_frame(8'h3C, 16'd0);
    test_frame(8'h3C, 16'd1);
    test_back_to_back();
    test_reset_abort();
    test_frame(8'h4D, 16'd3);
`ifdef UART_TX_PARITY_EN
    test_frame(8'h07, 16'd2);
    test_frame(8'h03, 16'd2);
`endif
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
